// File: rtl/as_pack.sv
// Shared constants and types for the memory-mapped GPIO controller.
package as_pack;

    localparam int nr_gpios          = 8;
    localparam int gpio_addr_width   = 4;
    localparam int gpio_cs_hold_max  = 15;
    localparam int gpio_cs_cnt_width = 4;

    typedef enum logic [2:0] {
        GPIO_DOUT  = 3'd0,
        GPIO_DIR   = 3'd1,
        GPIO_DIN   = 3'd2,
        GPIO_IE    = 3'd3,
        GPIO_ISTAT = 3'd4
    } gpio_reg_e;

    // Out-of-range hold values are clamped so the strobe always lasts 1..15 cycles.
    function automatic logic [gpio_cs_cnt_width-1:0] gpio_cs_load(input int hold);
        if (hold < 1) begin
            return gpio_cs_cnt_width'(1);
        end else if (hold > gpio_cs_hold_max) begin
            return gpio_cs_cnt_width'(gpio_cs_hold_max);
        end else begin
            return gpio_cs_cnt_width'(hold);
        end
    endfunction

endpackage

// File: rtl/as_gpio_sync.sv
// Parameterised-width two-flop synchroniser for asynchronous pin inputs.
module as_gpio_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= d_i;
            stage2_q <= stage1_q;
        end
    end

    assign q_o = stage2_q;

endmodule

// File: rtl/as_gpio_ctrl.sv
// GPIO controller on the data-memory bus: output/direction registers, synchronised
// input readback, rising-edge interrupts and a programmable chip-select strobe.
module as_gpio_ctrl
    import as_pack::*;
#(
    parameter int CS_HOLD = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_i,
    input  logic                       we_i,
    input  logic [gpio_addr_width-1:0] addr_i,
    input  logic [63:0]                wdata_i,
    output logic                       ack_o,
    output logic [63:0]                rdata_o,
    inout  wire  [nr_gpios-1:0]        gpio_io,
    output logic                       cs_o,
    output logic                       irq_o
);

    localparam logic [gpio_cs_cnt_width-1:0] CsLoad = gpio_cs_load(CS_HOLD);

    logic [nr_gpios-1:0]          dout_q,  dout_d;
    logic [nr_gpios-1:0]          dir_q,   dir_d;
    logic [nr_gpios-1:0]          ie_q,    ie_d;
    logic [nr_gpios-1:0]          istat_q, istat_d;
    logic [nr_gpios-1:0]          prev_q;
    logic [gpio_cs_cnt_width-1:0] csCnt_q, csCnt_d;
    logic [63:0]                  rdata_q, rdata_d;
    logic                         ack_q;
    logic                         irq_q,   irq_d;

    logic [nr_gpios-1:0] din;
    logic [nr_gpios-1:0] rise;
    logic [nr_gpios-1:0] wdat;
    logic [2:0]          regSel;
    logic                wrEn;
    logic                rdEn;
    logic                unusedBits;

    assign regSel     = addr_i[2:0];
    assign wdat       = wdata_i[nr_gpios-1:0];
    assign wrEn       = req_i & we_i;
    assign rdEn       = req_i & ~we_i;
    assign unusedBits = ^{addr_i[gpio_addr_width-1:3], wdata_i[63:nr_gpios]};

    // Pins are sampled whether driven externally or by us, so DIN reflects the real level.
    as_gpio_sync #(
        .WIDTH (nr_gpios)
    ) uSync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (gpio_io),
        .q_o   (din)
    );

    for (genvar k = 0; k < nr_gpios; k++) begin : gPin
        assign gpio_io[k] = dir_q[k] ? dout_q[k] : 1'bz;
    end

    assign rise = din & ~prev_q;

    always_comb begin
        dout_d  = dout_q;
        dir_d   = dir_q;
        ie_d    = ie_q;
        istat_d = istat_q;
        rdata_d = '0;
        csCnt_d = (csCnt_q != '0) ? csCnt_q - 1'b1 : '0;
        irq_d   = |(istat_q & ie_q);

        if (wrEn) begin
            case (regSel)
                GPIO_DOUT: begin
                    dout_d  = wdat;
                    csCnt_d = CsLoad;
                end
                GPIO_DIR:   dir_d   = wdat;
                GPIO_IE:    ie_d    = wdat;
                GPIO_ISTAT: istat_d = istat_q & ~wdat;
                default: ;
            endcase
        end

        // A new edge overrides a same-cycle clear so no event is ever lost.
        istat_d = istat_d | rise;

        if (rdEn) begin
            case (regSel)
                GPIO_DOUT:  rdata_d = 64'(dout_q);
                GPIO_DIR:   rdata_d = 64'(dir_q);
                GPIO_DIN:   rdata_d = 64'(din);
                GPIO_IE:    rdata_d = 64'(ie_q);
                GPIO_ISTAT: rdata_d = 64'(istat_q);
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dout_q  <= '0;
            dir_q   <= '0;
            ie_q    <= '0;
            istat_q <= '0;
            prev_q  <= '0;
            csCnt_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            dir_q   <= dir_d;
            ie_q    <= ie_d;
            istat_q <= istat_d;
            prev_q  <= din;
            csCnt_q <= csCnt_d;
            rdata_q <= rdata_d;
            ack_q   <= req_i;
            irq_q   <= irq_d;
        end
    end

    assign ack_o   = ack_q;
    assign rdata_o = rdata_q;
    assign cs_o    = (csCnt_q != '0);
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_as_gpio_ctrl.sv
// Scoreboard bench for as_gpio_ctrl: two instances (strobe hold 1 and 3) share one bus.
module tb_as_gpio_ctrl;
    import as_pack::*;

    typedef struct {
        logic        isRead;
        logic [63:0] data;
    } busExp_t;

    logic        clock;
    logic        reset;
    logic        reqA, reqB, weBus;
    logic [3:0]  addrBus;
    logic [63:0] wdataBus;
    logic        ackA, ackB, csA, csB, irqA, irqB;
    logic [63:0] rdataA, rdataB;
    wire  [7:0]  gpioA, gpioB;
    logic [7:0]  tbEnB, tbValB;

    busExp_t     expQA[$];
    busExp_t     expQB[$];
    logic [7:0]  csQA[$];
    logic [7:0]  csQB[$];
    int          nChecks;
    int          nFails;

    for (genvar k = 0; k < 8; k++) begin : gDrv
        assign gpioB[k] = tbEnB[k] ? tbValB[k] : 1'bz;
    end

    as_gpio_ctrl #(.CS_HOLD(1)) dutA (
        .clk_i(clock), .rst_i(reset), .req_i(reqA), .we_i(weBus), .addr_i(addrBus),
        .wdata_i(wdataBus), .ack_o(ackA), .rdata_o(rdataA), .gpio_io(gpioA),
        .cs_o(csA), .irq_o(irqA)
    );

    as_gpio_ctrl #(.CS_HOLD(3)) dutB (
        .clk_i(clock), .rst_i(reset), .req_i(reqB), .we_i(weBus), .addr_i(addrBus),
        .wdata_i(wdataBus), .ack_o(ackB), .rdata_o(rdataB), .gpio_io(gpioB),
        .cs_o(csB), .irq_o(irqB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus access; the expected response is queued before the request is sampled.
    task automatic applyStimulus(input logic side, input logic we, input logic [2:0] addr,
                                 input logic [63:0] data, input logic [63:0] expData);
        busExp_t e;
        e.isRead = ~we;
        e.data   = expData;
        if (side) expQB.push_back(e);
        else      expQA.push_back(e);
        weBus    = we;
        addrBus  = {1'b0, addr};
        wdataBus = data;
        reqA     = ~side;
        reqB     = side;
        @(posedge clock);
        #1;
        reqA = 1'b0;
        reqB = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Monitor: pops an expectation for every ack and for every cycle cs is high.
    always @(negedge clock) begin
        busExp_t e;
        if (ackA) begin
            if (expQA.size() == 0) begin
                checkOutput("unexpectedAckA", 1, 0);
            end else begin
                e = expQA.pop_front();
                if (e.isRead) checkOutput("rdataA", rdataA, e.data);
            end
        end
        if (ackB) begin
            if (expQB.size() == 0) begin
                checkOutput("unexpectedAckB", 1, 0);
            end else begin
                e = expQB.pop_front();
                if (e.isRead) checkOutput("rdataB", rdataB, e.data);
            end
        end
        if (csA) begin
            if (csQA.size() == 0) checkOutput("unexpectedCsA", 1, 0);
            else                  checkOutput("pinsAtCsA", {56'd0, gpioA}, {56'd0, csQA.pop_front()});
        end
        if (csB) begin
            if (csQB.size() == 0) checkOutput("unexpectedCsB", 1, 0);
            else                  checkOutput("pinsAtCsB", {56'd0, gpioB}, {56'd0, csQB.pop_front()});
        end
    end

    initial begin
        #100000;
        nFails++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] pat [4];
        pat      = '{8'd137, 8'd119, 8'd1, 8'd254};
        nChecks  = 0;
        nFails   = 0;
        reset    = 1'b0;
        reqA     = 1'b0;
        reqB     = 1'b0;
        weBus    = 1'b0;
        addrBus  = '0;
        wdataBus = '0;
        tbEnB    = 8'hFF;
        tbValB   = 8'h00;

        #2 reset = 1'b1;
        #1;
        checkOutput("resetCsA",   {63'd0, csA},  0);
        checkOutput("resetCsB",   {63'd0, csB},  0);
        checkOutput("resetAckB",  {63'd0, ackB}, 0);
        checkOutput("resetRdataB", rdataB,       0);
        checkOutput("resetIrqB",  {63'd0, irqB}, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        $display("[TB] back-to-back DOUT writes, hold 1");
        applyStimulus(0, 1, GPIO_DIR, 64'hFF, 0);
        for (int i = 0; i < 4; i++) begin
            csQA.push_back(pat[i]);
            applyStimulus(0, 1, GPIO_DOUT, {56'd0, pat[i]}, 0);
        end
        idleCycles(2);
        applyStimulus(0, 0, GPIO_DOUT, 0, 64'd254);
        applyStimulus(0, 0, GPIO_DIR,  0, 64'hFF);

        $display("[TB] pulse extension, hold 3");
        applyStimulus(1, 1, GPIO_DIR, 64'hFF, 0);
        tbEnB = 8'h00;
        csQB.push_back(8'h55);
        csQB.push_back(8'h55);
        applyStimulus(1, 1, GPIO_DOUT, 64'h55, 0);
        idleCycles(1);
        repeat (3) csQB.push_back(8'hAA);
        applyStimulus(1, 1, GPIO_DOUT, 64'hAA, 0);
        idleCycles(5);
        checkOutput("pinsAfterExtend", {56'd0, gpioB}, 64'hAA);

        $display("[TB] mixed direction readback");
        applyStimulus(1, 1, GPIO_DIR, 64'h0F, 0);
        tbValB = 8'hA0;
        tbEnB  = 8'hF0;
        repeat (3) csQB.push_back(8'hAF);
        applyStimulus(1, 1, GPIO_DOUT, 64'hFF, 0);
        checkOutput("pinsMixed", {56'd0, gpioB}, 64'hAF);
        idleCycles(2);
        applyStimulus(1, 0, GPIO_DIN, 0, 64'hAF);
        idleCycles(3);

        $display("[TB] rising-edge interrupt");
        applyStimulus(1, 1, GPIO_DIR, 64'h00, 0);
        tbValB = 8'hAE;
        tbEnB  = 8'hFF;
        idleCycles(4);
        applyStimulus(1, 0, GPIO_ISTAT, 0, 64'hFF);
        checkOutput("irqMaskedByIe", {63'd0, irqB}, 0);
        applyStimulus(1, 1, GPIO_ISTAT, 64'hFF, 0);
        applyStimulus(1, 0, GPIO_ISTAT, 0, 64'h00);
        applyStimulus(1, 1, GPIO_IE, 64'h01, 0);
        tbValB = 8'hAF;
        for (int i = 0; i < 3; i++) begin
            idleCycles(1);
            checkOutput("irqBeforeEdge", {63'd0, irqB}, 0);
        end
        applyStimulus(1, 0, GPIO_ISTAT, 0, 64'h01);
        checkOutput("irqAfterEdge", {63'd0, irqB}, 1);
        tbValB = 8'hAE;
        idleCycles(4);
        tbValB = 8'hAF;
        idleCycles(2);
        applyStimulus(1, 1, GPIO_ISTAT, 64'h01, 0);
        applyStimulus(1, 0, GPIO_ISTAT, 0, 64'h01);
        checkOutput("irqSetWins", {63'd0, irqB}, 1);
        applyStimulus(1, 1, GPIO_ISTAT, 64'h01, 0);
        applyStimulus(1, 0, GPIO_ISTAT, 0, 64'h00);
        idleCycles(1);
        checkOutput("irqCleared", {63'd0, irqB}, 0);

        $display("[TB] unmapped offsets");
        applyStimulus(1, 0, 3'd6, 0, 0);
        applyStimulus(1, 1, 3'd7, 64'hFF, 0);
        applyStimulus(1, 0, 3'd7, 0, 0);
        applyStimulus(1, 0, GPIO_DOUT, 0, 64'hFF);
        applyStimulus(1, 0, GPIO_DIR,  0, 64'h00);
        applyStimulus(1, 0, GPIO_IE,   0, 64'h01);

        $display("[TB] reset during strobe");
        applyStimulus(1, 1, GPIO_DIR, 64'hFF, 0);
        tbEnB = 8'h00;
        csQB.push_back(8'h3C);
        applyStimulus(1, 1, GPIO_DOUT, 64'h3C, 0);
        @(posedge clock);
        #1;
        reset  = 1'b1;
        tbValB = 8'h00;
        tbEnB  = 8'hFF;
        #1;
        checkOutput("csDropOnReset",   {63'd0, csB}, 0);
        checkOutput("pinsReleasedOnReset", {56'd0, gpioB}, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        idleCycles(1);
        applyStimulus(1, 0, GPIO_DOUT,  0, 0);
        applyStimulus(1, 0, GPIO_DIR,   0, 0);
        applyStimulus(1, 0, GPIO_DIN,   0, 0);
        applyStimulus(1, 0, GPIO_IE,    0, 0);
        applyStimulus(1, 0, GPIO_ISTAT, 0, 0);
        checkOutput("irqAfterReset", {63'd0, irqB}, 0);
        idleCycles(5);

        checkOutput("leftoverBusA", 64'(expQA.size()), 0);
        checkOutput("leftoverBusB", 64'(expQB.size()), 0);
        checkOutput("leftoverCsA",  64'(csQA.size()),  0);
        checkOutput("leftoverCsB",  64'(csQB.size()),  0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/as_gpio_ctrl.md
# as_gpio_ctrl

Memory-mapped GPIO controller that sits between the core's data-memory bus and the chip's `gpio_io` pins inside `as_top_mem`. It is the producer side of the GPIO/chip-select observation interface. A core store to the output-data register drives the new value onto the pins and raises `cs_o` for a programmable number of cycles, so an external observer can sample `gpio_io` while `cs_o` is high. It also synchronises pin inputs, provides readback, and raises an edge-triggered interrupt.

## Interface
- `CS_HOLD`, default 1: cycles `cs_o` stays high per output-data write; legal range 1..15.
- `clk_i` in 1: system clock; all state changes on its rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_i` in 1: bus request, valid for one cycle per access.
- `we_i` in 1: 1 = write, 0 = read; qualified by `req_i`.
- `addr_i` in `gpio_addr_width`: register word offset; only bits [2:0] are decoded.
- `wdata_i` in 64: write data; bits above `nr_gpios`-1 are ignored.
- `ack_o` out 1: one-cycle acknowledge for every request.
- `rdata_o` out 64: read data, zero-extended; valid while `ack_o` is high.
- `gpio_io` inout `nr_gpios`: pins; bit driven from DOUT when DIR=1, else high-Z.
- `cs_o` out 1: output-data strobe.
- `irq_o` out 1: level interrupt, the OR over (ISTAT & IE).

## Operation
- Register map (word offsets):
  - 0 DOUT, RW.
  - 1 DIR, RW; 1 = output.
  - 2 DIN, RO; synchronised pin levels.
  - 3 IE, RW; per-bit rising-edge interrupt enable.
  - 4 ISTAT, write-1-to-clear.
  - 5..7 unmapped: reads return 0, writes are ignored, but the access is still acknowledged.
- Reset values: DOUT, DIR, IE, ISTAT = 0. All pins are high-Z. `ack_o`, `rdata_o`, `cs_o`, `irq_o` = 0. Strobe counter = 0.
- Write to DOUT:
  - The register updates and the strobe counter loads `CS_HOLD`. `cs_o` = (counter != 0), and the counter decrements each cycle while non-zero.
  - The strobe fires even if every DOUT bit is configured as input.
  - Writing DIR, IE or ISTAT never touches `cs_o`.
- Write to DOUT while `cs_o` is already high: the counter reloads to `CS_HOLD`, so the pulse is extended, not queued.
- Input path:
  - Each pin passes through a 2-flop synchroniser; the second stage is DIN.
  - A third flop holds DIN from the previous cycle. A rising edge on bit k is DIN[k] & ~prev[k].
  - A rising edge sets ISTAT[k] regardless of IE; IE only masks `irq_o`.
  - Output pins are also observed through DIN, so DIN reads back the driven level.
- ISTAT write-1-to-clear: in the same cycle as a new edge on that bit, the set wins.

## Timing
- A request sampled at edge N produces `ack_o` = 1 and `rdata_o` valid after edge N, deasserting after edge N+1 unless another request arrives.
- Back-to-back requests each get their own ack; there is no wait state and no backpressure.
- A DOUT write sampled at edge N: the pins show the new value after edge N, and `cs_o` is high for cycles N..N+`CS_HOLD`-1. The pins are therefore stable throughout the strobe, so sampling at the negative edge is safe.
- Read data is the register contents before the same-edge write; there is no write-through.
- A pin change before edge M is visible in DIN after edge M+1 and sets ISTAT after edge M+2. `irq_o` is registered and follows after edge M+3.
- Reset asserted mid-strobe: `cs_o` drops immediately (asynchronous reset) and the pins go high-Z. After release, no strobe occurs until the next DOUT write.

## Structure
- Additions to `as_pack`:
  - `nr_gpios` and `gpio_addr_width` (existing).
  - Enum `gpio_reg_e` with offsets 0..4.
  - Constant `gpio_cs_hold_max` = 15.
- One sub-module, `as_gpio_sync`: parameterised-width 2-flop synchroniser with the async active-high reset and a reset value of 0.
- Tristate: per-bit continuous assign, `gpio_io[k]` = DIR[k] ? DOUT[k] : 'z.

## Test plan
- Reset, then write DIR=0xFF followed by DOUT=137, 119, 1, 254 back-to-back with `CS_HOLD`=1 -> four one-cycle `cs_o` pulses; at each pulse's negative edge `gpio_io` equals 137, 119, 1, 254 respectively.
- Set `CS_HOLD`=3; write DOUT=0x55, then DOUT=0xAA two cycles later -> `cs_o` stays high for 5 contiguous cycles, and the pins change to 0xAA at the second write.
- Write DIR=0x0F, DOUT=0xFF; drive the upper pins externally to 0xA0 -> the pins read 0xAF; a DIN read issued ≥2 cycles later returns 0xAF.
- Write IE=0x01, then drive pin 0 from 0 to 1 -> ISTAT[0] set after 3 edges and `irq_o`=1 one cycle later. Write ISTAT=0x01 on the same edge as a second rising edge -> ISTAT[0] remains 1.
- Read offset 6 and write offset 7 -> `ack_o` pulses, `rdata_o`=0, no register changes.
- Assert `rst_i` in the second cycle of a 3-cycle strobe -> `cs_o`=0 and the pins go high-Z immediately; all readbacks return 0 after release.
